// File: rtl/fft_idx_seq.sv
// FFT index sequencer: run-time loadable index table streamed as table, linear or
// bit-reversed index sequences over a valid/ready port with a 2-entry skid buffer.
module fft_idx_seq #(
    parameter int AW    = 8,
    parameter int DW    = 9,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_idx,
    output logic          out_last,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t        state, state_nx;
    logic [AW:0]   len_q, rd_cnt, beat_cnt, eff_len;
    logic [1:0]    mode_q;
    logic [DW-1:0] table_mem [DEPTH];
    logic [DW-1:0] ram_q;
    logic          p_vld;
    logic [AW-1:0] p_cnt;
    logic [DW-1:0] p_idx, brev;
    logic [DW-1:0] fifo_mem [2];
    logic          fifo_wp, fifo_rp;
    logic [1:0]    fifo_cnt;
    logic          issue, hs, push, pop, fifo_empty;

    assign eff_len = (len > DEPTH_L) ? DEPTH_L : len;
    assign busy    = (state != IDLE);

    // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE:  if (start && eff_len != '0) state_nx = RUN;
            RUN: begin
                // Credit gate: buffered beats plus the read in flight never exceed the FIFO depth.
                issue = (fifo_cnt + 2'(p_vld)) < 2'd2;
                if (issue && rd_cnt == len_q - ONE) state_nx = DRAIN;
            end
            DRAIN: if (hs && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            mode_q   <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            p_vld    <= 1'b0;
            p_cnt    <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == IDLE && start && eff_len == '0) ||
                     (state == DRAIN && hs && out_last);
            if (state == IDLE && start) begin
                len_q    <= eff_len;
                mode_q   <= mode;
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (issue) rd_cnt   <= rd_cnt + ONE;
                if (hs)    beat_cnt <= beat_cnt + ONE;
            end
            p_vld <= issue;
            if (issue) p_cnt <= rd_cnt[AW-1:0];
        end
    end

    // NOTE: the table and skid storage are not reset; they map to plain RAM/flops and the table survives rst_n.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy && ({1'b0, cfg_addr} < DEPTH_L))
            table_mem[cfg_addr] <= cfg_wdata;
        if (issue)
            ram_q <= table_mem[rd_cnt[AW-1:0]];
    end

    // Linear and bit-reverse indices come from the registered count, matching the RAM latency.
    always_comb begin
        brev = '0;
        for (int i = 0; i < AW; i++) brev[i] = p_cnt[AW-1-i];
        case (mode_q)
            2'd0:    p_idx = ram_q;
            2'd2:    p_idx = brev;
            default: p_idx = DW'(p_cnt);
        endcase
    end

    assign fifo_empty = (fifo_cnt == 2'd0);
    assign out_valid  = !fifo_empty || p_vld;
    assign hs         = out_valid && out_ready;
    assign pop        = hs && !fifo_empty;
    // A pipeline beat bypasses the FIFO only when the FIFO is empty and the consumer takes it now.
    assign push       = p_vld && !(fifo_empty && out_ready);
    assign out_idx    = !out_valid ? '0 : (fifo_empty ? p_idx : fifo_mem[fifo_rp]);
    assign out_last   = out_valid && (beat_cnt == len_q - ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wp] <= p_idx;
                fifo_wp           <= ~fifo_wp;
            end
            if (pop) fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_fft_idx_seq.sv
// Scoreboard bench for fft_idx_seq: expected beats are queued at start and
// popped by a negedge monitor on each handshake.
module tb_fft_idx_seq;
    localparam int AW    = 8;
    localparam int DW    = 9;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [1:0]    mode = '0;
    logic          busy, out_valid, out_last, done;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_idx;

    fft_idx_seq #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .len(len), .mode(mode),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            checks = 0;
    int            errors = 0;
    int            beats  = 0;
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] model [DEPTH];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_idx;
    logic          prev_last;
    logic [DW:0]   e;

    // Monitor: scoreboard pop on handshake plus hold-stable check during stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_idx !== prev_idx || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold @%0d: valid=%b idx=%h last=%b, required valid=1 idx=%h last=%b",
                             cyc, out_valid, out_idx, out_last, prev_idx, prev_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat @%0d: got idx=%h last=%b, required no beat", cyc, out_idx, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_idx} !== e) begin
                        errors++;
                        $display("FAIL beat @%0d: got last=%b idx=%h, required last=%b idx=%h",
                                 cyc, out_last, out_idx, e[DW], e[DW-1:0]);
                    end
                end
            end
            prev_stall = (out_valid === 1'b1 && out_ready !== 1'b1);
            prev_idx   = out_idx;
            prev_last  = out_last;
        end
    end

    task automatic push_exp(input int l, input int m);
        int n;
        logic [DW-1:0] v;
        n = (l > DEPTH) ? DEPTH : l;
        for (int c = 0; c < n; c++) begin
            if (m == 0) v = model[c];
            else if (m == 2) begin
                v = '0;
                for (int b = 0; b < AW; b++) if (((c >> b) & 1) == 1) v[AW-1-b] = 1'b1;
            end else v = DW'(c);
            exp_q.push_back({(c == n - 1), v});
        end
    endtask

    task automatic do_start(input int l, input int m, output int t);
        @(posedge clk); #1;
        start = 1'b1; len = (AW+1)'(l); mode = 2'(m);
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin dc = cyc; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, out_valid, out_idx, out_last, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b idx=%h last=%b done=%b, required all 0",
                     busy, out_valid, out_idx, out_last, done);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic load_table;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            cfg_we = 1'b1; cfg_addr = AW'(i);
            cfg_wdata = (i < 240) ? DW'(i + 1) : DW'(i ^ 'h155);
            model[i] = cfg_wdata;
        end
        @(posedge clk); #1 cfg_we = 1'b0;
    endtask

    task automatic test_table_240;
        int t, dc;
        beats = 0;
        push_exp(240, 0);
        do_start(240, 0, t);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_state: busy=%b valid=%b, required busy=1 valid=0", busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t2_first_valid: valid=%b, required 1", out_valid);
        end
        wait_done(dc);
        checks++;
        if (dc !== t + 242 || busy !== 1'b0) begin
            errors++;
            $display("FAIL table240_done: done at %0d busy=%b, required %0d busy=0", dc, busy, t + 242);
        end
        checks++;
        if (beats !== 240 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL table240_count: beats=%0d left=%0d, required 240 and 0", beats, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b, required 0", done);
        end
    endtask

    task automatic test_bitrev;
        int t, dc;
        beats = 0;
        push_exp(16, 2);
        do_start(16, 2, t);
        wait_done(dc);
        checks++;
        if (dc < 0 || beats !== 16 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL bitrev_count: done=%0d beats=%0d left=%0d, required 16 and 0", dc, beats, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int t, dc;
        logic [3:0] pat;
        pat = 4'b1001;
        beats = 0;
        dc = -1;
        push_exp(8, 1);
        do_start(8, 1, t);
        for (int k = 0; k < 200; k++) begin
            out_ready = pat[k % 4];
            @(negedge clk);
            if (done === 1'b1) begin dc = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1 out_ready = 1'b1;
        checks++;
        if (dc < 0 || beats !== 8 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL backpressure_count: done=%0d beats=%0d left=%0d, required 8 and 0", dc, beats, exp_q.size());
        end
    endtask

    task automatic test_len0;
        int t;
        do_start(0, 0, t);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: done=%b busy=%b valid=%b, required 1 0 0", done, busy, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL len0_quiet: valid=%b done=%b, required 0 0", out_valid, done);
            end
        end
    endtask

    task automatic test_clamp;
        int t, dc;
        beats = 0;
        push_exp(300, 1);
        do_start(300, 1, t);
        wait_done(dc);
        checks++;
        if (dc < 0 || beats !== 256 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL clamp_count: done=%0d beats=%0d left=%0d, required 256 and 0", dc, beats, exp_q.size());
        end
    endtask

    task automatic test_start_busy;
        int t, t2, dc;
        beats = 0;
        push_exp(10, 3);
        do_start(10, 3, t);
        @(posedge clk);
        do_start(3, 0, t2);
        wait_done(dc);
        checks++;
        if (dc < 0 || beats !== 10 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL start_busy_count: done=%0d beats=%0d left=%0d, required 10 and 0", dc, beats, exp_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL start_busy_quiet: busy=%b done=%b valid=%b, required 0 0 0", busy, done, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid;
        int t, dc;
        beats = 0;
        push_exp(20, 1);
        do_start(20, 1, t);
        for (int i = 0; i < 100 && beats < 5; i++) @(negedge clk);
        checks++;
        if (beats < 5) begin
            errors++;
            $display("FAIL reset_mid_progress: beats=%0d, required at least 5", beats);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, out_valid, out_idx, out_last, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b valid=%b idx=%h last=%b done=%b, required all 0",
                     busy, out_valid, out_idx, out_last, done);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
        beats = 0;
        push_exp(4, 0);
        do_start(4, 0, t);
        wait_done(dc);
        checks++;
        if (dc < 0 || beats !== 4 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid_restart: done=%0d beats=%0d left=%0d, required 4 and 0", dc, beats, exp_q.size());
        end
    endtask

    task automatic test_cfg_busy;
        int t, dc;
        beats = 0;
        push_exp(8, 1);
        do_start(8, 1, t);
        cfg_we = 1'b1; cfg_addr = AW'(3); cfg_wdata = DW'('h1FF);
        @(posedge clk); #1 cfg_we = 1'b0;
        wait_done(dc);
        checks++;
        if (dc < 0 || beats !== 8) begin
            errors++;
            $display("FAIL cfg_busy_run: done=%0d beats=%0d, required 8", dc, beats);
        end
        beats = 0;
        push_exp(4, 0);
        do_start(4, 0, t);
        wait_done(dc);
        checks++;
        if (dc < 0 || beats !== 4 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL cfg_busy_table: done=%0d beats=%0d left=%0d, required 4 and 0", dc, beats, exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        load_table;
        test_table_240;
        test_bitrev;
        test_backpressure;
        test_len0;
        test_clamp;
        test_start_busy;
        test_reset_mid;
        test_cfg_busy;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
